sevenseg_scan_controller: RTL and testbench

Time-multiplexes one shared active-low cathode bus across NUM_DIGITS anodes of the seven-segment display. Advances one digit per scan_en strobe from the clock divider, which is 4 kHz at a 100 MHz clk. Inserts an anti-ghosting blank gap between digits. Display values are swapped atomically at frame boundaries through a req/ack handshake with the score/timer logic.

---
 rtl/sevenseg_pkg.sv | 22 ++
 rtl/sevenseg_hex_decoder.sv | 11 +
 rtl/sevenseg_scan_controller.sv | 191 +++++++++++++++++++
 tb/tb_sevenseg_scan_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan FSM states, active-low segment patterns and a digit-count range check.
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index n holds the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_DECODE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic bit num_digits_ok(input int n);
        return (n >= 2) && (n <= 8);
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_DECODE[nibble];

endmodule

// File: rtl/sevenseg_scan_controller.sv
// Multiplexed seven-segment scan with anti-ghost blank gap and frame-atomic
// shadow update. Optional blinking is built when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan_controller
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_en,
`ifdef SEVENSEG_BLINK_EN
    input  logic                    tick_1hz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_blank_en,
    input  logic                    upd_req,
    output logic                    upd_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int              IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]      GAP_LAST = 8'(BLANK_CYCLES - 1);

    if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
        $error("sevenseg_scan_controller: NUM_DIGITS must be in 2..8");
    end

    scan_state_t            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             gap_q, gap_d;
    logic                   boundary;

    logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]  sdp_q, sdp_d;
    logic [NUM_DIGITS-1:0]  sblank_q, sblank_d;
    logic [NUM_DIGITS-1:0]  lz_dark;
    logic                   zero_run;
    logic                   dark;
    logic [3:0]             nib_sel;
    logic [6:0]             seg_dec;
    logic [NUM_DIGITS-1:0]  an_d;
    logic [6:0]             seg_d;
    logic                   dp_d;

    // ---------------- scan FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            idx_q   <= LAST_IDX;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            BLANK: begin
                if (gap_q == GAP_LAST) begin
                    state_d = DRIVE;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            DRIVE: begin
                if (scan_en) begin
                    state_d = BLANK;
                    gap_d   = '0;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    assign boundary = (state_q == BLANK) && (gap_q == GAP_LAST) && (idx_q == LAST_IDX);

    // The ack is a Mealy term so the requester sees it in the very cycle the
    // shadows capture; reset masks it so a pending request is never acked.
    assign upd_ack = boundary & upd_req & ~rst;

    // ---------------- shadow registers ----------------
    always_comb begin
        nib_d    = nib_q;
        sdp_d    = sdp_q;
        sblank_d = sblank_q;
        if (upd_ack) begin
            nib_d    = digits_in;
            sdp_d    = dp_in;
            sblank_d = blank_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_q    <= '0;
            sdp_q    <= '0;
            sblank_q <= '1;
        end else begin
            nib_q    <= nib_d;
            sdp_q    <= sdp_d;
            sblank_q <= sblank_d;
        end
    end

`ifdef SEVENSEG_BLINK_EN
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] sblink_q, sblink_d;

    assign phase_d  = phase_q ^ tick_1hz;
    assign sblink_d = upd_ack ? blink_mask : sblink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 1'b0;
            sblink_q <= '0;
        end else begin
            phase_q  <= phase_d;
            sblink_q <= sblink_d;
        end
    end
`endif

    // Leading-zero run scanned from the top digit down; digit 0 always shows.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (nib_d[i] == 4'h0);
            lz_dark[i] = lz_blank_en && zero_run;
        end
    end

    // ---------------- output decode ----------------
    // Outputs are built from next-state and next-shadow values so the
    // registered anode and its segment data always switch on the same edge.
    assign nib_sel = nib_d[idx_d];

    sevenseg_hex_decoder u_dec (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

`ifdef SEVENSEG_BLINK_EN
    assign dark = sblank_d[idx_d] | lz_dark[idx_d] | (phase_d & sblink_d[idx_d]);
`else
    assign dark = sblank_d[idx_d] | lz_dark[idx_d];
`endif

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            if (!dark) begin
                seg_d = seg_dec;
                dp_d  = ~sdp_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// Self-checking bench: random display values and scan timing checked against
// an arithmetic model of what each digit should show. Blink tests need SEVENSEG_BLINK_EN.
module tb_sevenseg_scan_controller;

    localparam int ND = 4;
    localparam int BC = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           scan_en;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]  dp_in;
    logic [ND-1:0]  blank_in;
    logic           lz_blank_en;
    logic           upd_req;
    logic           upd_ack;
    logic [ND-1:0]  an;
    logic [6:0]     seg;
    logic           dp;
    logic           frame_start;
`ifdef SEVENSEG_BLINK_EN
    logic           tick_1hz;
    logic [ND-1:0]  blink_mask;
`endif

    int checks = 0;
    int errors = 0;

    // Model: shadow contents as plain values, plus which digit is showing.
    logic [15:0]    m_nib;
    logic [ND-1:0]  m_dp;
    logic [ND-1:0]  m_blank;
    logic [ND-1:0]  m_blink;
    bit             m_phase;
    int             m_digit;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sevenseg_scan_controller #(.NUM_DIGITS(ND), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
`ifdef SEVENSEG_BLINK_EN
        .tick_1hz    (tick_1hz),
        .blink_mask  (blink_mask),
`endif
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_blank_en (lz_blank_en),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {dp, seg} expected on digit i given the model's shadow values.
    function automatic logic [7:0] exp_out(input int i);
        bit dark;
        int nib;
        nib  = int'((m_nib >> (4 * i)) & 16'hF);
        dark = m_blank[i];
        if (lz_blank_en && i >= 1 && (m_nib >> (4 * i)) == 16'h0) dark = 1;
        if (m_phase && m_blink[i]) dark = 1;
        if (dark) return 8'hFF;
        return {~m_dp[i], dec_tab[nib]};
    endfunction

    task automatic model_reset();
        m_nib   = '0;
        m_dp    = '0;
        m_blank = '1;
        m_blink = '0;
        m_phase = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg_dp", 32'({dp, seg}), 32'hFF);
        check("rst_ack", 32'(upd_ack), 0);
        check("rst_fs", 32'(frame_start), 0);
    endtask

    task automatic check_drive(input bit first);
        logic [ND-1:0] a;
        a = ~(ND'(1) << m_digit);
        check("drv_an", 32'(an), 32'(a));
        check("drv_seg_dp", 32'({dp, seg}), 32'(exp_out(m_digit)));
        check("drv_fs", 32'(frame_start), 32'(first && m_digit == 0));
        check("drv_ack", 32'(upd_ack), 0);
    endtask

    // Called at the first blank cycle: checks the gap and the next digit.
    task automatic gap_then_drive(input int nxt);
        bit acked;
        acked = 0;
        for (int b = 0; b < BC; b++) begin
            check("gap_an", 32'(an), 32'hF);
            check("gap_fs", 32'(frame_start), 0);
            if (b == BC - 1 && nxt == 0 && upd_req) begin
                acked   = 1;
                m_nib   = digits_in;
                m_dp    = dp_in;
                m_blank = blank_in;
`ifdef SEVENSEG_BLINK_EN
                m_blink = blink_mask;
`endif
            end
            check("gap_ack", 32'(upd_ack), 32'(acked));
            tick();
            scan_en = 0;
        end
        if (acked) upd_req = 0;
        m_digit = nxt;
        check_drive(1);
    endtask

    task automatic dwell(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_drive(0);
        end
    endtask

    task automatic scan(input bit extra);
        scan_en = 1;
        tick();
        scan_en = extra;   // a second strobe lands in BLANK and must be dropped
        gap_then_drive((m_digit + 1) % ND);
    endtask

    task automatic frame();
        for (int k = 0; k < ND; k++) begin
            dwell(int'($urandom_range(0, 3)));
            scan(0);
        end
    endtask

    task automatic request(input logic [15:0] nib, input logic [ND-1:0] dpv,
                           input logic [ND-1:0] blk, input logic [ND-1:0] blm, input bit lz);
        digits_in   = nib;
        dp_in       = dpv;
        blank_in    = blk;
        lz_blank_en = lz;
`ifdef SEVENSEG_BLINK_EN
        blink_mask  = blm;
`else
        if (blm != '0) m_blink = '0;
`endif
        upd_req = 1;
        do begin
            dwell(int'($urandom_range(0, 2)));
            scan(0);
        end while (m_digit != 0);
    endtask

`ifdef SEVENSEG_BLINK_EN
    task automatic blink_tick();
        tick_1hz = 1;
        tick();
        tick_1hz = 0;
        m_phase = ~m_phase;
        check_drive(0);
    endtask
`endif

    initial begin
        rst = 1; scan_en = 0; digits_in = '0; dp_in = '0; blank_in = '0;
        lz_blank_en = 0; upd_req = 0;
`ifdef SEVENSEG_BLINK_EN
        tick_1hz = 0; blink_mask = '0;
`endif
        model_reset();
        m_digit = ND - 1;
        repeat (3) tick();
        check_reset_outputs();

        // Post-reset: digit 0 appears after the gap with no strobe; a strobe
        // during the gap is ignored. Display stays dark until updated.
        rst = 0;
        scan_en = 1;
        gap_then_drive(0);
        frame();
        dwell(30);
        frame();

        // Request raised on digit 1, inputs changed mid-frame: only the values
        // present at the boundary may appear.
        scan(0);
        digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = '0;
        upd_req = 1;
        dwell(2);
        scan(0);
        digits_in = 16'h1234; dp_in = 4'b0000;
        dwell(1);
        scan(0);
        scan(0);
        frame();

        // A second strobe right after the first has no effect.
        scan(1);
        scan(1);
        dwell(2);
        scan(0);
        scan(0);

        // Leading-zero suppression.
        request(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1);
        frame();
        request(16'h0000, 4'b0010, 4'b0000, 4'b0000, 1);
        frame();

        for (int r = 0; r < 5; r++) begin
            logic [15:0] mask;
            mask = (r % 3 == 0) ? 16'h00FF : (r % 3 == 1) ? 16'h0FFF : 16'hFFFF;
            request(16'($urandom) & mask, 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                    4'b0000, bit'($urandom_range(0, 1)));
            frame();
        end

`ifdef SEVENSEG_BLINK_EN
        request(16'($urandom) | 16'h1000, 4'($urandom), 4'b0000, 4'b0001, 0);
        for (int k = 0; k < 4; k++) begin
            dwell(2);
            blink_tick();
            frame();
        end
`endif

        // Reset mid-frame with a pending request: no ack, outputs back to reset.
        while (m_digit != 2) scan(0);
        digits_in = 16'hABCD;
        upd_req = 1;
        rst = 1;
        tick();
        check_reset_outputs();
        rst = 0;
        upd_req = 0;
        model_reset();
        gap_then_drive(0);
        frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
